// File: rtl/axi_lite_if.sv
`timescale 1ns/1ps
// axi_lite_if: AXI4-Lite signal bundle (AW/W/B/AR/R channels).
//   master modport: drives awvalid/awaddr/wvalid/wdata/wstrb/bready/arvalid/araddr/rready
//   slave modport : drives awready/wready/bvalid/bresp/arready/rvalid/rdata/rresp
interface axi_lite_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_master.sv
`timescale 1ns/1ps
// axi_lite_master: single-outstanding AXI4-Lite master. Turns a valid/ready
// request (read or write) into one AXI4-Lite transaction and holds the
// registered response until the requester takes it.
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (req_ready only in IDLE)
//   req_we/addr/wdata/wstrb : request payload (1 = write)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata/rsp_err     : read data (0 for writes), error = resp[1]
//   m                     : AXI4-Lite master port
module axi_lite_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    axi_lite_if.master          m
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                arvalid_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    logic rready, bready;
    logic accept;
    logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic aw_fin, w_fin;
    logic unused_resp_lsb;

    assign accept = req_valid && req_ready;
    assign ar_hs  = arvalid_q && m.arready;
    assign aw_hs  = awvalid_q && m.awready;
    assign w_hs   = wvalid_q && m.wready;
    assign r_hs   = m.rvalid && rready;
    assign b_hs   = m.bvalid && bready;

    // A write channel is finished once its valid has dropped or it handshakes
    // this cycle; the two channels complete independently.
    assign aw_fin = !awvalid_q || m.awready;
    assign w_fin  = !wvalid_q || m.wready;

    // Only resp[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    assign unused_resp_lsb = m.rresp[0] ^ m.bresp[0];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = req_we ? WR_REQ : RD_ADDR;
            RD_ADDR: if (ar_hs) state_d = RD_DATA;
            RD_DATA: if (r_hs) state_d = RESP;
            WR_REQ:  if (aw_fin && w_fin) state_d = WR_RESP;
            WR_RESP: if (b_hs) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rready    = 1'b0;
        bready    = 1'b0;
        unique case (state_q)
            IDLE:    req_ready = 1'b1;
            RD_DATA: rready    = 1'b1;
            WR_RESP: bready    = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request payload, channel valids and response registers. Payload is
    // held until the next accept so slaves may keep decoding the address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                wstrb_q   <= req_wstrb;
                arvalid_q <= !req_we;
                awvalid_q <= req_we;
                wvalid_q  <= req_we;
            end
            if (ar_hs) arvalid_q <= 1'b0;
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
            if (r_hs) begin
                rsp_rdata_q <= m.rdata;
                rsp_err_q   <= m.rresp[1];
            end
            if (b_hs) begin
                rsp_rdata_q <= '0;
                rsp_err_q   <= m.bresp[1];
            end
        end
    end

    assign m.arvalid = arvalid_q;
    assign m.araddr  = addr_q;
    assign m.awvalid = awvalid_q;
    assign m.awaddr  = addr_q;
    assign m.wvalid  = wvalid_q;
    assign m.wdata   = wdata_q;
    assign m.wstrb   = wstrb_q;
    assign m.rready  = rready;
    assign m.bready  = bready;

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite master: converts a simple valid/ready request/response port into AXI4-Lite read or write transactions.
- Sits between a CPU-side requester (LSU, or IFU for reads) and the AXI4-Lite interconnect.
- Drives slaves such as clint and the memory/UART bridges.
- Exactly one transaction is in flight at any time; the response is registered and held until the requester consumes it.

Parameters:
- ADDR_W, 32, address width of request port and AXI address channels.
- DATA_W, 32, data width; wstrb width is DATA_W/8.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request offered.
- req_ready  output  1  master can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  byte address, forwarded unmodified (alignment is the requester's job).
- req_wdata  input  DATA_W  write data.
- req_wstrb  input  DATA_W/8  write byte strobes.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  requester consumes response.
- rsp_rdata  output  DATA_W  read data; 0 for writes.
- rsp_err  output  1  1 when rresp/bresp[1] = 1 (SLVERR/DECERR).
- m  axi_lite_if.master  -  all AW/W/B/AR/R signals; master drives awvalid/awaddr/wvalid/wdata/wstrb/bready/arvalid/araddr/rready.

Behaviour:
- Reset (reset_n low, async): state IDLE, awvalid = wvalid = arvalid = bready = rready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, awaddr/araddr/wdata = 0, wstrb = 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- req_ready = (state == IDLE), combinational from state only; never depends on req_valid.
- Accept:
  - On req_valid && req_ready, latch addr/wdata/wstrb into output registers.
  - Next state is RD_ADDR if req_we = 0, else WR_REQ.
- RD_ADDR:
  - arvalid = 1 from the cycle after accept.
  - On arvalid && arready, go to RD_DATA; arvalid drops that edge.
- RD_DATA:
  - rready = 1.
  - On rvalid && rready, capture rdata into rsp_rdata, set rsp_err = rresp[1], go to RESP.
- WR_REQ:
  - awvalid and wvalid both assert the cycle after accept.
  - Track aw_done and w_done independently; each valid drops the edge after its own handshake.
  - When both are done (same cycle or different cycles), go to WR_RESP.
  - Never re-assert a channel after its handshake.
- WR_RESP:
  - bready = 1.
  - On bvalid && bready, set rsp_err = bresp[1], rsp_rdata = 0, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata/rsp_err stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE.
- araddr/awaddr/wdata/wstrb hold their latched value until the next accept. Slaves that decode araddr during the R phase rely on this.
- AXI valids obey protocol: once asserted, held with stable payload until the handshake. Valids never depend combinationally on ready.
- Minimum latency with a zero-wait slave (arready = 1, rvalid the cycle after AR):
  - read: accept T0, AR T1, R T2, rsp_valid T3.
  - write: accept T0, AW+W T1, B T2, rsp_valid T3.
- Back-to-back: the next request is accepted no earlier than the cycle after the rsp handshake (IDLE for at least one cycle).
- Reset mid-transaction: all outputs return to reset values immediately and the in-flight transaction is abandoned. Slaves share the reset domain.
- Unexpected rvalid/bvalid outside RD_DATA/WR_RESP: ignored (ready is 0), no state change.

Test Plan:
- Read clint: read 0x0a000048, then 0x0a00004c -> rsp_err = 0 both times. Repeat the low read 10 cycles later -> rsp_rdata is larger by at least 10. Latency matches T3.
- Write clint: write 0x0a000048 with wdata 0xdeadbeef, wstrb 0xf -> clint returns bresp 2'b10 -> rsp_valid with rsp_err = 1, rsp_rdata = 0.
- Skewed write: model slave with awready low for 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with awaddr stable, a single B handshake, one response.
- Backpressure: rsp_ready held low for 5 cycles after read of 0x80000000 (model returns 0x12345678) -> rsp_valid/rsp_rdata stable, req_ready = 0 throughout, IDLE on the cycle after rsp_ready.
- Reset mid-read: drop reset_n while in RD_DATA -> arvalid/rready/rsp_valid go 0 asynchronously. After release, the first read of 0x80000004 completes normally.
- Protocol checker: 200 random reads/writes with random slave stalls -> no valid drops before handshake, no payload change while valid, at most one outstanding transaction, responses in order.
